// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: program-RAM read port, redirect input and the
// instruction hand-off to the control unit.
interface fetch_unit_if #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int INSTR_BYTES = 3,
    parameter int DEPTH       = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                          mem_rd_en;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_data;
    logic                          redirect_valid;
    logic [ADDR_W-1:0]             redirect_pc;
    logic                          instr_ready;
    logic                          instr_valid;
    logic [INSTR_BYTES*DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0]             instr_pc;
    logic                          halted;
    logic [CNT_W-1:0]              buf_count;

    // Fetch unit side
    modport master (
        output mem_rd_en, mem_addr, instr_valid, instr_data, instr_pc, halted, buf_count,
        input  mem_data, redirect_valid, redirect_pc, instr_ready
    );

    // Memory / control-unit side
    modport slave (
        input  mem_rd_en, mem_addr, instr_valid, instr_data, instr_pc, halted, buf_count,
        output mem_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: streams bytes from a synchronous program RAM, assembles them
// into INSTR_BYTES-wide words (opcode in the MSBs) and queues up to DEPTH
// complete instructions. Supports redirect flush, back-pressure and halt.
module fetch_unit #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                INSTR_BYTES = 3,
    parameter int                DEPTH       = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int IW    = INSTR_BYTES * DATA_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [IDX_W-1:0]  iss_idx_q, iss_idx_d;     // byte index of next issue
    logic [CNT_W-1:0]  resv_q, resv_d;           // instructions issued, not yet pushed
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;       // byte index of the read on the bus
    logic              rsp_vld_q, rsp_vld_d;     // mem_data carries a wanted byte
    logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [IW-1:0]     asm_q, asm_d;
    logic [ADDR_W-1:0] asm_pc_q, asm_pc_d;
    logic              halt_seen_q, halt_seen_d; // halt opcode captured
    logic [IW-1:0]     buf_data_q [DEPTH];
    logic [IW-1:0]     buf_data_d [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q [DEPTH];
    logic [ADDR_W-1:0] buf_pc_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic cap, push, pop, issue, slot_ok;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: capture/assembly, issue decision, buffer update, redirect override
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        iss_idx_d   = iss_idx_q;
        resv_d      = resv_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        rd_idx_d    = rd_idx_q;
        rsp_vld_d   = mem_rd_en_q;
        rsp_idx_d   = rd_idx_q;
        rsp_addr_d  = mem_addr_q;
        asm_d       = asm_q;
        asm_pc_d    = asm_pc_q;
        halt_seen_d = halt_seen_q;
        buf_data_d  = buf_data_q;
        buf_pc_d    = buf_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        issue       = 1'b0;
        cap         = rsp_vld_q;
        push        = rsp_vld_q && (rsp_idx_q == LAST_IDX);
        pop         = (count_q != '0) && bus.instr_ready;
        // Registered count only: a pop frees its slot for this check next cycle.
        slot_ok     = ({1'b0, count_q} + {1'b0, resv_q}) < (CNT_W + 1)'(DEPTH);

        if (cap) begin
            for (int i = 0; i < INSTR_BYTES; i++)
                if (rsp_idx_q == IDX_W'(i))
                    asm_d[(INSTR_BYTES - i) * DATA_W - 1 -: DATA_W] = bus.mem_data;
            if (rsp_idx_q == '0) begin
                asm_pc_d = rsp_addr_q;
                if (bus.mem_data == HALT_OPCODE) halt_seen_d = 1'b1;
            end
        end

        // Trailing bytes never stall; only an opcode byte waits for a slot.
        unique case (state_q)
            S_RUN, S_STALL: begin
                if (iss_idx_q != '0) begin
                    issue = 1'b1;
                end else if (!halt_seen_q) begin
                    if (slot_ok) begin
                        issue   = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_STALL;
                    end
                end
            end
            default: ;
        endcase

        if (issue) begin
            mem_rd_en_d = 1'b1;
            mem_addr_d  = fetch_pc_q;
            rd_idx_d    = iss_idx_q;
            fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
            iss_idx_d   = idx_inc(iss_idx_q);
            if (iss_idx_q == '0) resv_d = resv_d + CNT_W'(1);
        end

        if (push) begin
            resv_d               = resv_d - CNT_W'(1);
            buf_data_d[wr_ptr_q] = asm_d;
            buf_pc_d[wr_ptr_q]   = asm_pc_d;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
            if (halt_seen_d) state_d = S_HALT;
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Redirect flushes everything and issues the target opcode byte at once.
        if (bus.redirect_valid) begin
            state_d     = S_RUN;
            halt_seen_d = 1'b0;
            rsp_vld_d   = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = bus.redirect_pc;
            rd_idx_d    = '0;
            fetch_pc_d  = bus.redirect_pc + ADDR_W'(1);
            iss_idx_d   = idx_inc('0);
            resv_d      = CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            fetch_pc_q  <= RESET_PC;
            iss_idx_q   <= '0;
            resv_q      <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            rd_idx_q    <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_addr_q  <= '0;
            asm_q       <= '0;
            asm_pc_q    <= '0;
            halt_seen_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            iss_idx_q   <= iss_idx_d;
            resv_q      <= resv_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            rd_idx_q    <= rd_idx_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_addr_q  <= rsp_addr_d;
            asm_q       <= asm_d;
            asm_pc_q    <= asm_pc_d;
            halt_seen_q <= halt_seen_d;
            buf_data_q  <= buf_data_d;
            buf_pc_q    <= buf_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr_data  = buf_data_q[rd_ptr_q];
    assign bus.instr_pc    = buf_pc_q[rd_ptr_q];
    assign bus.halted      = (state_q == S_HALT);
    assign bus.buf_count   = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, first fetch, halt and resume,
// redirect mid-instruction with a same-cycle pop, back-pressure, mid-fetch
// reset, and PC wrap on a second instance starting at 8'hFE.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] ram [256];

    always #5 clk = ~clk;

    fetch_unit_if #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3), .DEPTH(2)) bus_a ();
    fetch_unit_if #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3), .DEPTH(2)) bus_b ();

    fetch_unit #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3), .DEPTH(2),
                 .RESET_PC(8'h00), .HALT_OPCODE(8'hFF))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));

    fetch_unit #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3), .DEPTH(2),
                 .RESET_PC(8'hFE), .HALT_OPCODE(8'hFF))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

    // Synchronous program RAM models, one read port per instance
    always @(posedge clk) begin
        if (bus_a.mem_rd_en) bus_a.mem_data <= ram[bus_a.mem_addr];
        if (bus_b.mem_rd_en) bus_b.mem_data <= ram[bus_b.mem_addr];
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, ".rd_en"},  32'(bus_a.mem_rd_en),   0);
        chk({tag, ".addr"},   32'(bus_a.mem_addr),    0);
        chk({tag, ".valid"},  32'(bus_a.instr_valid), 0);
        chk({tag, ".data"},   32'(bus_a.instr_data),  0);
        chk({tag, ".pc"},     32'(bus_a.instr_pc),    0);
        chk({tag, ".halted"}, 32'(bus_a.halted),      0);
        chk({tag, ".count"},  32'(bus_a.buf_count),   0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h00] = 8'h10; ram[8'h01] = 8'h20; ram[8'h02] = 8'h30;
        ram[8'h03] = 8'h31; ram[8'h04] = 8'h32; ram[8'h05] = 8'h33;
        ram[8'h06] = 8'hFF; ram[8'h07] = 8'hAA; ram[8'h08] = 8'hBB;
        ram[8'h10] = 8'hA1; ram[8'h11] = 8'hA2; ram[8'h12] = 8'hA3;
        ram[8'h13] = 8'hB1; ram[8'h14] = 8'hB2; ram[8'h15] = 8'hB3;
        ram[8'h16] = 8'hC1; ram[8'h17] = 8'hC2; ram[8'h18] = 8'hC3;
        ram[8'h19] = 8'hD1; ram[8'h1A] = 8'hD2; ram[8'h1B] = 8'hD3;
        ram[8'h40] = 8'h40; ram[8'h41] = 8'h41; ram[8'h42] = 8'h42;
        ram[8'h43] = 8'h43; ram[8'h44] = 8'h44; ram[8'h45] = 8'h45;
        ram[8'hFE] = 8'hE1; ram[8'hFF] = 8'hE2;

        bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = 8'h00; bus_a.instr_ready = 1'b1;
        bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = 8'h00; bus_b.instr_ready = 1'b1;

        // Reset values
        step(2);
        chk_reset_a("rst");
        chk("rst.b_rd_en", 32'(bus_b.mem_rd_en), 0);

        // First fetch: cycle c is the first with rst=0
        rst = 1'b0;
        step(1); // c+1
        chk("c1.rd_en", 32'(bus_a.mem_rd_en), 1);
        chk("c1.addr",  32'(bus_a.mem_addr),  32'h00);
        chk("wrap.c1",  32'(bus_b.mem_addr),  32'hFE);
        step(1); // c+2
        chk("c2.addr",  32'(bus_a.mem_addr),  32'h01);
        chk("wrap.c2",  32'(bus_b.mem_addr),  32'hFF);
        step(1); // c+3
        chk("c3.addr",  32'(bus_a.mem_addr),  32'h02);
        chk("wrap.c3",  32'(bus_b.mem_addr),  32'h00);
        step(1); // c+4
        chk("c4.valid", 32'(bus_a.instr_valid), 0);
        step(1); // c+5
        chk("c5.valid", 32'(bus_a.instr_valid), 1);
        chk("c5.data",  32'(bus_a.instr_data),  32'h102030);
        chk("c5.pc",    32'(bus_a.instr_pc),    32'h00);
        chk("wrap.pc0",   32'(bus_b.instr_pc),   32'hFE);
        chk("wrap.data0", 32'(bus_b.instr_data), 32'hE1E210);
        step(3); // c+8
        chk("c8.data",  32'(bus_a.instr_data),  32'h313233);
        chk("c8.pc",    32'(bus_a.instr_pc),    32'h03);
        chk("wrap.pc1",   32'(bus_b.instr_pc),   32'h01);
        chk("wrap.data1", 32'(bus_b.instr_data), 32'h203031);

        // Halt at address 6: bytes 6..8 still fetched, nothing after
        step(1); // c+9
        chk("halt.last_rd", 32'(bus_a.mem_addr), 32'h08);
        step(1); // c+10
        chk("halt.no_rd",   32'(bus_a.mem_rd_en), 0);
        step(1); // c+11
        chk("halt.valid",  32'(bus_a.instr_valid), 1);
        chk("halt.data",   32'(bus_a.instr_data),  32'hFFAABB);
        chk("halt.pc",     32'(bus_a.instr_pc),    32'h06);
        chk("halt.halted", 32'(bus_a.halted),      1);
        step(3); // c+14
        chk("halt.hold_rd",  32'(bus_a.mem_rd_en), 0);
        chk("halt.hold_hlt", 32'(bus_a.halted),    1);
        chk("halt.empty",    32'(bus_a.instr_valid), 0);

        // Redirect to 0 releases the halt
        bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 8'h00;
        step(1); // r0+1
        bus_a.redirect_valid = 1'b0;
        chk("resume.halted", 32'(bus_a.halted),    0);
        chk("resume.rd_en",  32'(bus_a.mem_rd_en), 1);
        chk("resume.addr",   32'(bus_a.mem_addr),  32'h00);
        step(4); // r0+5
        chk("resume.valid",  32'(bus_a.instr_valid), 1);
        chk("resume.data",   32'(bus_a.instr_data),  32'h102030);
        chk("redir.byte1",   32'(bus_a.mem_addr),    32'h04);

        // Redirect while byte 1 of instr 03 is in flight, pop in the same cycle
        bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 8'h40;
        step(1); // r1+1
        bus_a.redirect_valid = 1'b0;
        chk("redir.valid", 32'(bus_a.instr_valid), 0);
        chk("redir.count", 32'(bus_a.buf_count),   0);
        chk("redir.rd_en", 32'(bus_a.mem_rd_en),   1);
        chk("redir.addr",  32'(bus_a.mem_addr),    32'h40);
        step(4); // r1+5
        chk("redir.tvalid", 32'(bus_a.instr_valid), 1);
        chk("redir.tpc",    32'(bus_a.instr_pc),    32'h40);
        chk("redir.tdata",  32'(bus_a.instr_data),  32'h404142);
        step(3); // r1+8
        chk("redir.npc",    32'(bus_a.instr_pc),    32'h43);
        chk("redir.ndata",  32'(bus_a.instr_data),  32'h434445);

        // Back-pressure: redirect to 0x10 with the consumer stalled
        bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 8'h10; bus_a.instr_ready = 1'b0;
        step(1); // r2+1
        bus_a.redirect_valid = 1'b0;
        chk("bp.first_addr", 32'(bus_a.mem_addr), 32'h10);
        step(6); // r2+7
        chk("bp.stall_rd",   32'(bus_a.mem_rd_en), 0);
        step(1); // r2+8
        chk("bp.count",      32'(bus_a.buf_count),  2);
        chk("bp.head_data",  32'(bus_a.instr_data), 32'hA1A2A3);
        chk("bp.head_pc",    32'(bus_a.instr_pc),   32'h10);
        step(4); // r2+12
        chk("bp.hold_rd",    32'(bus_a.mem_rd_en),  0);
        chk("bp.hold_count", 32'(bus_a.buf_count),  2);
        chk("bp.hold_data",  32'(bus_a.instr_data), 32'hA1A2A3);
        bus_a.instr_ready = 1'b1; // single pop at p
        step(1); // p+1
        bus_a.instr_ready = 1'b0;
        chk("bp.pop_count",  32'(bus_a.buf_count),  1);
        chk("bp.pop_head",   32'(bus_a.instr_data), 32'hB1B2B3);
        step(1); // p+2
        chk("bp.refill0",    32'(bus_a.mem_addr),   32'h16);
        chk("bp.refill_en",  32'(bus_a.mem_rd_en),  1);
        step(2); // p+4
        chk("bp.refill2",    32'(bus_a.mem_addr),   32'h18);
        step(1); // p+5
        chk("bp.once",       32'(bus_a.mem_rd_en),  0);
        step(1); // p+6
        chk("bp.full",       32'(bus_a.buf_count),  2);
        step(2); // p+8
        chk("bp.still_idle", 32'(bus_a.mem_rd_en),  0);
        chk("bp.order_pc",   32'(bus_a.instr_pc),   32'h13);
        bus_a.instr_ready = 1'b1;
        step(1); // p+9
        bus_a.instr_ready = 1'b0;
        chk("bp.order_c",    32'(bus_a.instr_data), 32'hC1C2C3);
        chk("bp.order_cpc",  32'(bus_a.instr_pc),   32'h16);

        // Reset in the middle of a fetch
        step(1); // p+10
        chk("midrst.rd_en",  32'(bus_a.mem_rd_en),  1);
        chk("midrst.addr",   32'(bus_a.mem_addr),   32'h19);
        chk("midrst.valid",  32'(bus_a.instr_valid), 1);
        rst = 1'b1;
        step(1);
        chk_reset_a("midrst");
        chk("midrst.b_rd_en", 32'(bus_b.mem_rd_en), 0);
        rst = 1'b0; bus_a.instr_ready = 1'b1;
        step(1);
        chk("rerun.addr0",   32'(bus_a.mem_addr),  32'h00);
        chk("rerun.rd_en",   32'(bus_a.mem_rd_en), 1);
        step(4);
        chk("rerun.valid",   32'(bus_a.instr_valid), 1);
        chk("rerun.data",    32'(bus_a.instr_data),  32'h102030);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch front-end for the multi-cycle processor: it replaces the fixed PC, MAR and 24-bit instruction-register path with one block. It streams bytes from the synchronous program RAM, assembles them into INSTR_BYTES-wide command words, and buffers up to DEPTH complete instructions for the control unit. It adds redirect (jump/branch) flushing, back-pressure and halt detection, none of which the current fetch path has.

## Interface
- DATA_W, 8, memory byte width
- ADDR_W, 8, program address width; the PC wraps modulo 2^ADDR_W
- INSTR_BYTES, 3, bytes per instruction; the first byte fetched is the opcode and occupies the MSBs
- DEPTH, 2, instruction buffer entries (≥1)
- RESET_PC, 0, fetch address after reset
- HALT_OPCODE, 8'hFF, opcode byte that stops fetching
- clk  in  1  single clock; everything updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_rd_en  out  1  RAM read strobe (registered)
- mem_addr  out  ADDR_W  RAM read address (registered)
- mem_data  in  DATA_W  RAM data; valid exactly one cycle after a cycle with mem_rd_en=1
- redirect_valid  in  1  load a new PC and flush
- redirect_pc  in  ADDR_W  new fetch address
- instr_ready  in  1  consumer takes the buffer head
- instr_valid  out  1  buffer non-empty
- instr_data  out  INSTR_BYTES*DATA_W  head instruction
- instr_pc  out  ADDR_W  address of the head instruction's opcode byte
- halted  out  1  halt opcode assembled; fetch stopped
- buf_count  out  clog2(DEPTH+1)  entries held

## Operation
- **Reset values.** mem_rd_en=0, mem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, halted=0, buf_count=0. The internal fetch_pc is set to RESET_PC and the byte index to 0.
- **States.**
  - RUN: issues reads.
  - STALL: waits for a buffer slot.
  - HALT: stopped.
- **Issuing.**
  - Byte 0 of an instruction is issued only if buf_count + reserved < DEPTH. The reserved flag is set when byte 0 issues and cleared when the instruction is written to the buffer.
  - Bytes 1..INSTR_BYTES-1 issue on consecutive cycles with no gaps.
  - Each issue drives mem_addr=fetch_pc, then fetch_pc+1 with wrap from 2^ADDR_W-1 to 0. An instruction may straddle the wrap.
- **Assembly.**
  - The response byte i is placed in bits [(INSTR_BYTES-i)*DATA_W-1 -: DATA_W].
  - When the last byte is captured, the word is pushed together with its opcode address.
- **Halt.**
  - If the captured opcode byte equals HALT_OPCODE, the remaining bytes of that instruction are still fetched and the instruction is still pushed.
  - No further byte 0 is issued, and halted=1 from the cycle after the push.
  - Only redirect or rst clears the halt.
- **STALL.** Entered when byte 0 is blocked; RUN is re-entered the cycle after a pop makes the check pass. A pop does not free a slot for the check until the next cycle, because the check uses registered buf_count.
- **Pop.** Occurs when instr_valid && instr_ready. A pop and a push in the same cycle are both performed, and buf_count is unchanged.
- **Redirect.** Has the highest priority below rst. In the cycle after it is sampled:
  - the buffer is empty, instr_valid=0 and halted=0;
  - the reserved flag and byte index are cleared;
  - any response still in flight is discarded;
  - fetch_pc=redirect_pc + 1, and mem_rd_en=1 with mem_addr=redirect_pc;
  - a pop in the same cycle as the redirect is ignored.
- **Reset mid-fetch.** Abandons everything; the behaviour is identical to power-on reset.

## Timing
- With c = the first cycle with rst=0:
  - mem_rd_en is high in c+1 .. c+INSTR_BYTES;
  - the first instr_valid is in cycle c+INSTR_BYTES+2 (c+5 for the defaults).
- Redirect sampled in cycle r: the first instr_valid at the target is in r+INSTR_BYTES+2.
- Steady state with instr_ready held at 1: one instruction every INSTR_BYTES cycles, and mem_rd_en is continuously high.
- instr_data and instr_pc are stable while instr_valid=1 and instr_ready=0.

## Test plan
- **Reset and first fetch.** RAM[0..2]=10,20,30 and instr_ready=1. Required: reads at addresses 0,1,2 in c+1..c+3; instr_valid in c+5 with instr_data=24'h102030 and instr_pc=0.
- **Back-pressure.** instr_ready=0 and the program has no halt. Required: after two instructions, buf_count=2 and mem_rd_en stays 0. Pulse instr_ready once: exactly one more 3-byte fetch follows, and the order is preserved.
- **Redirect mid-instruction.** Assert redirect_pc=8'h40 while byte 1 of the instruction at 8'h03 is in flight. Required: the next cycle shows instr_valid=0 and mem_addr=8'h40; the next instruction delivered has instr_pc=8'h40, with no bytes from 8'h03.
- **Halt.** RAM[6]=8'hFF. Required: the instruction at 6 is delivered; halted=1; no read issues after address 8. Then redirect to 0: halted=0 and fetch resumes.
- **Wrap.** RESET_PC=8'hFE. Required: reads at FE, FF, 00; instr_pc=8'hFE; the next instr_pc=8'h01.
- **Simultaneous events.** Redirect and pop in the same cycle: buffer flushed and buf_count=0. rst asserted mid-fetch: all outputs return to their reset values the next cycle.
